// File: rtl/regfile_dump_sequencer.sv
// Register-file dump sequencer: walks reg_addr across a register range and streams (addr, data) beats on valid/ready.
// Optional running checksum of the delivered beats is enabled by defining DUMP_CHECKSUM_EN.
module regfile_dump_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRESENT,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FIRST_REG + NUM_REGS - 1);
  localparam logic [2:0]        LAT_INIT   = 3'(READ_LAT);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       accept;
  logic       start_ok;

  assign accept   = dump_valid && dump_ready;
  assign start_ok = (state == S_IDLE) && start && !abort;

  // busy and done decode straight from the state register, so they are glitch-free and
  // done lasts exactly the single FIN cycle.
  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  // NOTE: all state and output registers use non-blocking assignments so every branch sees
  // the values from the start of the cycle; reg_addr is deliberately not cleared on return
  // to IDLE, keeping the last probed register visible on the debug port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_cnt    <= 3'd0;
      reg_addr   <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            reg_addr <= FIRST_ADDR;
            lat_cnt  <= LAT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (lat_cnt == 3'd0) begin
            dump_data  <= reg_data;
            dump_addr  <= reg_addr;
            dump_valid <= 1'b1;
            state      <= S_PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            dump_valid <= 1'b0;
            if (abort) begin
              state <= S_IDLE;
            end else if (dump_addr == LAST_ADDR) begin
              state <= S_FIN;
            end else begin
              reg_addr <= reg_addr + ADDR_W'(1);
              lat_cnt  <= LAT_INIT;
              state    <= S_WAIT;
            end
          end else if (abort) begin
            dump_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_FIN: begin
          // abort is ignored here: the dump already completed, so the done pulse stands.
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // A beat accepted in the same cycle as abort still counts as delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + dump_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
